// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter sharing one FIFO write port among NREQ
//             valid/ready requesters. A granted requester gets a burst of
//             at most BURST_MAX words. No write is issued while the FIFO
//             reports full.
//  Ports    : clk_i         FIFO write clock
//             rst_n_i       asynchronous active-low reset
//             req_valid_i   per-requester valid            [NREQ]
//             req_data_i    per-requester data (k*WIDTH +: WIDTH)
//             req_ready_o   per-requester ready, at most one bit high
//             fifo_full_i   FIFO full flag
//             fifo_wr_en_o  FIFO write enable
//             fifo_wdata_o  FIFO write data
//             grant_o       one-hot current grant, zero while idle
//             grant_id_o    index of current / last granted requester
//             busy_o        high while a burst is in progress
//             stat_clr_i    (FIFO_WR_ARB_STATS_EN) synchronous counter clear
//             stat_cnt_o    (FIFO_WR_ARB_STATS_EN) 16-bit accepted-word count
//                           per requester, saturating
//  Options  : define FIFO_WR_ARB_STATS_EN to add the statistics counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_MAX = 4,
  parameter int IDW       = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NREQ-1:0]         req_valid_i,
  input  logic [NREQ*WIDTH-1:0]   req_data_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic                    fifo_full_i,
  output logic                    fifo_wr_en_o,
  output logic [WIDTH-1:0]        fifo_wdata_o,
  output logic [NREQ-1:0]         grant_o,
  output logic [IDW-1:0]          grant_id_o,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                    stat_clr_i,
  output logic [NREQ*16-1:0]      stat_cnt_o,
`endif
  output logic                    busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  localparam logic [7:0]      c_last_beat = 8'(BURST_MAX - 1);
  localparam logic [IDW-1:0]  c_gid_rst   = IDW'(NREQ - 1);
  localparam logic [NREQ-1:0] c_one       = {{(NREQ-1){1'b0}}, 1'b1};

  state_t          r_state;
  logic [NREQ-1:0] r_grant;
  logic [IDW-1:0]  r_gid;
  logic [7:0]      r_cnt;

  logic            w_found;
  logic [IDW-1:0]  w_pick;
  logic            w_valid_g;
  logic [WIDTH-1:0] w_data_g;
  logic            w_busy;
  logic            w_wr_en;
  logic            w_last_beat;
  logic            w_went_idle;

  // Round-robin search starting just above r_gid: first scan the indices
  // above the last winner, then wrap and scan from 0 up to it.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_gid;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid_i[k] && (IDW'(k) > r_gid)) begin
        w_found = 1'b1;
        w_pick  = IDW'(k);
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid_i[k] && (IDW'(k) <= r_gid)) begin
        w_found = 1'b1;
        w_pick  = IDW'(k);
      end
    end
  end

  // One-hot mux of the granted requester's valid and data.
  always_comb begin
    w_valid_g = 1'b0;
    w_data_g  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (r_grant[k]) begin
        w_valid_g = req_valid_i[k];
        w_data_g  = req_data_i[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_busy      = (r_state == ST_BURST);
  assign w_wr_en     = w_busy && w_valid_g && !fifo_full_i;
  assign w_last_beat = w_wr_en && (r_cnt == c_last_beat);
  // A dropped valid only ends the burst when the FIFO could have taken data.
  assign w_went_idle = !w_valid_g && !fifo_full_i;

  // Handshake outputs derive from the registered grant, so an asynchronous
  // reset clearing the grant drops ready and write enable at once.
  assign req_ready_o  = (w_busy && !fifo_full_i) ? r_grant : '0;
  assign fifo_wr_en_o = w_wr_en;
  assign fifo_wdata_o = w_wr_en ? w_data_g : '0;
  assign grant_o      = r_grant;
  assign grant_id_o   = r_gid;
  assign busy_o       = w_busy;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_gid   <= c_gid_rst;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_BURST;
            r_grant <= c_one << w_pick;
            r_gid   <= w_pick;
            r_cnt   <= 8'd0;
          end
        end
        ST_BURST: begin
          if (w_wr_en) begin
            r_cnt <= r_cnt + 8'd1;
          end
          if (w_last_beat || w_went_idle) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  for (genvar k = 0; k < NREQ; k++) begin : g_stats
    logic [15:0] r_stat;

    // Clear has priority over a coinciding transfer; count saturates.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_stat <= 16'd0;
      end else if (stat_clr_i) begin
        r_stat <= 16'd0;
      end else if (w_wr_en && r_grant[k] && (r_stat != 16'hFFFF)) begin
        r_stat <= r_stat + 16'd1;
      end
    end

    assign stat_cnt_o[k*16 +: 16] = r_stat;
  end
`endif

endmodule

`default_nettype wire
